// File: rtl/tlb_mp_if.sv
// tlb_mp_if: lookup, fill and page-table-walk request signals of tlb_mp.
//   slave  modport: the TLB side (receives lookups/fills, issues walk requests)
//   master modport: the MMU front ends + PTW side
// Lookup (per port): lu_access_i, lu_asid_i, lu_vaddr_i -> lu_hit_o, lu_content_o,
//                    lu_is_2M_o, lu_is_1G_o
// Fill from PTW    : update_*_i, ptw_error_i
// Walk request     : ptw_req_valid_o/ptw_req_ready_i handshake with port/vpn/asid
// PTEs are carried as raw 64-bit Sv39 PTEs (bit 5 is the G bit).
interface tlb_mp_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ASID_WIDTH = 16
);
  localparam int unsigned VLEN   = 39;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]                 lu_access_i;
  logic [NUM_PORTS-1:0][ASID_WIDTH-1:0] lu_asid_i;
  logic [NUM_PORTS-1:0][VLEN-1:0]       lu_vaddr_i;
  logic [NUM_PORTS-1:0]                 lu_hit_o;
  logic [NUM_PORTS-1:0][63:0]           lu_content_o;
  logic [NUM_PORTS-1:0]                 lu_is_2M_o;
  logic [NUM_PORTS-1:0]                 lu_is_1G_o;

  logic                  update_valid_i;
  logic                  update_is_2M_i;
  logic                  update_is_1G_i;
  logic [26:0]           update_vpn_i;
  logic [ASID_WIDTH-1:0] update_asid_i;
  logic [63:0]           update_content_i;
  logic                  ptw_error_i;

  logic                  ptw_req_valid_o;
  logic                  ptw_req_ready_i;
  logic [PORT_W-1:0]     ptw_req_port_o;
  logic [26:0]           ptw_req_vpn_o;
  logic [ASID_WIDTH-1:0] ptw_req_asid_o;

  modport slave (
    input  lu_access_i, lu_asid_i, lu_vaddr_i,
    output lu_hit_o, lu_content_o, lu_is_2M_o, lu_is_1G_o,
    input  update_valid_i, update_is_2M_i, update_is_1G_i, update_vpn_i,
    input  update_asid_i, update_content_i, ptw_error_i,
    output ptw_req_valid_o, ptw_req_port_o, ptw_req_vpn_o, ptw_req_asid_o,
    input  ptw_req_ready_i
  );

  modport master (
    output lu_access_i, lu_asid_i, lu_vaddr_i,
    input  lu_hit_o, lu_content_o, lu_is_2M_o, lu_is_1G_o,
    output update_valid_i, update_is_2M_i, update_is_1G_i, update_vpn_i,
    output update_asid_i, update_content_i, ptw_error_i,
    input  ptw_req_valid_o, ptw_req_port_o, ptw_req_vpn_o, ptw_req_asid_o,
    output ptw_req_ready_i
  );
endinterface

// File: rtl/tlb_mp.sv
// tlb_mp: multi-port fully associative Sv39 TLB with a single outstanding
// page-table-walk request shared by all lookup ports.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                SFENCE.VMA strobe
//   asid_to_be_flushed_i   SFENCE rs2 (0 = all address spaces)
//   vaddr_to_be_flushed_i  SFENCE rs1 (0 = all pages)
//   bus                    tlb_mp_if.slave: lookups, fills, walk request
//   walk_busy_o            miss FSM not IDLE
//
// state   | meaning
// IDLE    | no walk outstanding; arbitrates misses round-robin
// REQ     | walk request presented, waiting for ptw_req_ready_i
// WAIT    | walk accepted, waiting for fill or ptw_error_i
module tlb_mp #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ASID_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [38:0]           vaddr_to_be_flushed_i,
  tlb_mp_if.slave               bus,
  output logic                  walk_busy_o
);
  localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTE_G  = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  logic [TLB_ENTRIES-1:0]                 valid_q, valid_d;
  logic [TLB_ENTRIES-1:0]                 is_2M_q, is_2M_d;
  logic [TLB_ENTRIES-1:0]                 is_1G_q, is_1G_d;
  logic [TLB_ENTRIES-1:0][ASID_WIDTH-1:0] asid_q, asid_d;
  logic [TLB_ENTRIES-1:0][26:0]           vpn_q, vpn_d;
  logic [TLB_ENTRIES-1:0][63:0]           content_q, content_d;
  logic [TLB_ENTRIES-2:0]                 plru_q, plru_d;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [PORT_W-1:0]     rr_q, rr_d;
  logic [PORT_W-1:0]     req_port_q, req_port_d;
  logic [26:0]           req_vpn_q, req_vpn_d;
  logic [ASID_WIDTH-1:0] req_asid_q, req_asid_d;

  logic [NUM_PORTS-1:0][TLB_ENTRIES-1:0] lu_match;
  logic [NUM_PORTS-1:0]                  miss;
  logic [TLB_ENTRIES-1:0]                plru_sel;
  logic [TLB_ENTRIES-1:0]                flush_inv;
  logic [IDX_W-1:0]                      victim_idx, wr_idx, dup_idx, inv_idx, plru_idx;
  logic                                  dup_found, inv_found, fill_en;
  logic                                  grant_valid;
  logic [PORT_W-1:0]                     grant_port;

  // 4K/2M/1G-aware VPN compare
  function automatic logic page_match(input logic [26:0] tag, input logic is_2m,
                                      input logic is_1g, input logic [26:0] vpn);
    return (tag[26:18] == vpn[26:18]) &&
           (is_1g || ((tag[17:9] == vpn[17:9]) && (is_2m || (tag[8:0] == vpn[8:0]))));
  endfunction

  always_comb begin
    lu_match = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int e = 0; e < TLB_ENTRIES; e++) begin
        lu_match[p][e] = valid_q[e] &&
                         ((asid_q[e] == bus.lu_asid_i[p]) || content_q[e][PTE_G]) &&
                         page_match(vpn_q[e], is_2M_q[e], is_1G_q[e], bus.lu_vaddr_i[p][38:12]);
      end
    end
  end

  // Outputs are OR-reduced over a one-hot match, so a miss yields all zeros.
  always_comb begin
    bus.lu_hit_o     = '0;
    bus.lu_content_o = '0;
    bus.lu_is_2M_o   = '0;
    bus.lu_is_1G_o   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int e = 0; e < TLB_ENTRIES; e++) begin
        if (lu_match[p][e]) begin
          bus.lu_hit_o[p]     = 1'b1;
          bus.lu_content_o[p] = bus.lu_content_o[p] | content_q[e];
          bus.lu_is_2M_o[p]   = bus.lu_is_2M_o[p] | is_2M_q[e];
          bus.lu_is_1G_o[p]   = bus.lu_is_1G_o[p] | is_1G_q[e];
        end
      end
    end
  end

  always_comb begin
    miss = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      miss[p] = bus.lu_access_i[p] && !bus.lu_hit_o[p];
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unique
    a_unique_hit: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(lu_match[gp]));
  end

  // Each node points away from the most recently used half; later ports
  // overwrite shared nodes of earlier ports.
  always_comb begin
    plru_d = plru_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.lu_access_i[p]) begin
        for (int e = 0; e < TLB_ENTRIES; e++) begin
          if (lu_match[p][e]) begin
            for (int lvl = 0; lvl < IDX_W; lvl++) begin
              plru_d[IDX_W'((1 << lvl) - 1 + (e >> (IDX_W - lvl)))] =
                ~1'((e >> (IDX_W - 1 - lvl)) & 1);
            end
          end
        end
      end
    end
  end

  // Victim selection: lowest invalid entry first, else the PLRU leaf.
  always_comb begin
    plru_sel  = '1;
    plru_idx  = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      for (int lvl = 0; lvl < IDX_W; lvl++) begin
        if (plru_q[IDX_W'((1 << lvl) - 1 + (e >> (IDX_W - lvl)))] !=
            1'((e >> (IDX_W - 1 - lvl)) & 1)) begin
          plru_sel[e] = 1'b0;
        end
      end
    end
    for (int e = TLB_ENTRIES - 1; e >= 0; e--) begin
      if (plru_sel[e]) plru_idx = IDX_W'(e);
      if (!valid_q[e]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(e);
      end
    end
    victim_idx = inv_found ? inv_idx : plru_idx;
  end

  always_comb begin
    dup_found = 1'b0;
    dup_idx   = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      if (valid_q[e] && (asid_q[e] == bus.update_asid_i) && (vpn_q[e] == bus.update_vpn_i) &&
          (is_2M_q[e] == bus.update_is_2M_i) && (is_1G_q[e] == bus.update_is_1G_i)) begin
        dup_found = 1'b1;
        dup_idx   = IDX_W'(e);
      end
    end
    wr_idx = dup_found ? dup_idx : victim_idx;
  end

  always_comb begin
    flush_inv = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      if (asid_to_be_flushed_i == '0) begin
        flush_inv[e] = (vaddr_to_be_flushed_i == '0) ||
                       page_match(vpn_q[e], is_2M_q[e], is_1G_q[e], vaddr_to_be_flushed_i[38:12]);
      end else begin
        flush_inv[e] = !content_q[e][PTE_G] && (asid_q[e] == asid_to_be_flushed_i) &&
                       ((vaddr_to_be_flushed_i == '0) ||
                        page_match(vpn_q[e], is_2M_q[e], is_1G_q[e], vaddr_to_be_flushed_i[38:12]));
      end
    end
  end

  // A fill racing a flush, or returning for a walk that a flush has overtaken,
  // would reinstate a stale translation.
  assign fill_en = bus.update_valid_i && !flush_i && !((state_q == ST_WAIT) && drop_q);

  always_comb begin
    valid_d   = valid_q;
    is_2M_d   = is_2M_q;
    is_1G_d   = is_1G_q;
    asid_d    = asid_q;
    vpn_d     = vpn_q;
    content_d = content_q;
    if (flush_i) begin
      valid_d = valid_q & ~flush_inv;
    end else if (fill_en) begin
      valid_d[wr_idx]   = 1'b1;
      is_2M_d[wr_idx]   = bus.update_is_2M_i;
      is_1G_d[wr_idx]   = bus.update_is_1G_i;
      asid_d[wr_idx]    = bus.update_asid_i;
      vpn_d[wr_idx]     = bus.update_vpn_i;
      content_d[wr_idx] = bus.update_content_i;
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!grant_valid && miss[(int'(rr_q) + k) % NUM_PORTS]) begin
        grant_valid = 1'b1;
        grant_port  = PORT_W'((int'(rr_q) + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    drop_d              = drop_q;
    rr_d                = rr_q;
    req_port_d          = req_port_q;
    req_vpn_d           = req_vpn_q;
    req_asid_d          = req_asid_q;
    bus.ptw_req_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid && !flush_i) begin
          req_port_d = grant_port;
          req_vpn_d  = bus.lu_vaddr_i[grant_port][38:12];
          req_asid_d = bus.lu_asid_i[grant_port];
          rr_d       = PORT_W'((int'(grant_port) + 1) % NUM_PORTS);
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.ptw_req_valid_o = 1'b1;
        if (flush_i) drop_d = 1'b1;
        if (bus.ptw_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (bus.update_valid_i || bus.ptw_error_i) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ptw_req_port_o = req_port_q;
  assign bus.ptw_req_vpn_o  = req_vpn_q;
  assign bus.ptw_req_asid_o = req_asid_q;
  assign walk_busy_o        = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      is_2M_q    <= '0;
      is_1G_q    <= '0;
      asid_q     <= '0;
      vpn_q      <= '0;
      content_q  <= '0;
      plru_q     <= '0;
      state_q    <= ST_IDLE;
      drop_q     <= 1'b0;
      rr_q       <= '0;
      req_port_q <= '0;
      req_vpn_q  <= '0;
      req_asid_q <= '0;
    end else begin
      valid_q    <= valid_d;
      is_2M_q    <= is_2M_d;
      is_1G_q    <= is_1G_d;
      asid_q     <= asid_d;
      vpn_q      <= vpn_d;
      content_q  <= content_d;
      plru_q     <= plru_d;
      state_q    <= state_d;
      drop_q     <= drop_d;
      rr_q       <= rr_d;
      req_port_q <= req_port_d;
      req_vpn_q  <= req_vpn_d;
      req_asid_q <= req_asid_d;
    end
  end
endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed bench for tlb_mp (8 entries, 2 ports, 16-bit ASID).
module tb_tlb_mp;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i;
  logic [15:0] asid_fl;
  logic [38:0] vaddr_fl;
  logic        walk_busy_o;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  tlb_mp_if #(.NUM_PORTS(2), .ASID_WIDTH(16)) bus ();

  tlb_mp #(.TLB_ENTRIES(8), .NUM_PORTS(2), .ASID_WIDTH(16)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .asid_to_be_flushed_i  (asid_fl),
    .vaddr_to_be_flushed_i (vaddr_fl),
    .bus                   (bus),
    .walk_busy_o           (walk_busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i              = 1'b0;
    asid_fl              = '0;
    vaddr_fl             = '0;
    bus.lu_access_i      = '0;
    bus.lu_asid_i        = '0;
    bus.lu_vaddr_i       = '0;
    bus.update_valid_i   = 1'b0;
    bus.update_is_2M_i   = 1'b0;
    bus.update_is_1G_i   = 1'b0;
    bus.update_vpn_i     = '0;
    bus.update_asid_i    = '0;
    bus.update_content_i = '0;
    bus.ptw_error_i      = 1'b0;
    bus.ptw_req_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic fill(input logic [15:0] asid, input logic [26:0] vpn, input logic is2m,
                      input logic is1g, input logic [63:0] content);
    bus.update_valid_i   = 1'b1;
    bus.update_asid_i    = asid;
    bus.update_vpn_i     = vpn;
    bus.update_is_2M_i   = is2m;
    bus.update_is_1G_i   = is1g;
    bus.update_content_i = content;
    tick();
    bus.update_valid_i   = 1'b0;
  endtask

  task automatic set_lu(input int p, input logic acc, input logic [15:0] asid, input logic [38:0] va);
    bus.lu_access_i[p] = acc;
    bus.lu_asid_i[p]   = asid;
    bus.lu_vaddr_i[p]  = va;
  endtask

  task automatic test_reset();
    do_reset();
    set_lu(0, 1'b1, 16'd0, 39'h0);
    set_lu(1, 1'b1, 16'd5, 39'h1234_5678);
    #1;
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.ptw_req_valid_o); end
    n_cmp++; if (walk_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", walk_busy_o); end
    n_cmp++; if ({bus.ptw_req_port_o, bus.ptw_req_vpn_o, bus.ptw_req_asid_o} !== '0) begin n_err++; $display("FAIL reset_fields: got %h/%h/%h want 0", bus.ptw_req_port_o, bus.ptw_req_vpn_o, bus.ptw_req_asid_o); end
    n_cmp++; if (bus.lu_hit_o !== 2'b00) begin n_err++; $display("FAIL reset_hit: got %b want 00", bus.lu_hit_o); end
    n_cmp++; if (bus.lu_content_o[0] !== 64'h0) begin n_err++; $display("FAIL reset_content: got %h want 0", bus.lu_content_o[0]); end
  endtask

  task automatic test_lookup();
    do_reset();
    fill(16'd5, 27'h12345, 1'b0, 1'b0, 64'h0000_0000_1234_50CF);
    set_lu(0, 1'b1, 16'd5, 39'h1234_5678);
    #1;
    n_cmp++; if (bus.lu_hit_o[0] !== 1'b1) begin n_err++; $display("FAIL lookup_hit: got %b want 1", bus.lu_hit_o[0]); end
    n_cmp++; if (bus.lu_content_o[0] !== 64'h0000_0000_1234_50CF) begin n_err++; $display("FAIL lookup_content: got %h want 12345_0cf", bus.lu_content_o[0]); end
    n_cmp++; if ({bus.lu_is_2M_o[0], bus.lu_is_1G_o[0]} !== 2'b00) begin n_err++; $display("FAIL lookup_size: got %b want 00", {bus.lu_is_2M_o[0], bus.lu_is_1G_o[0]}); end
    set_lu(0, 1'b1, 16'd6, 39'h1234_5678);
    #1;
    n_cmp++; if (bus.lu_hit_o[0] !== 1'b0) begin n_err++; $display("FAIL lookup_asid_miss: got %b want 0", bus.lu_hit_o[0]); end
    n_cmp++; if (bus.lu_content_o[0] !== 64'h0) begin n_err++; $display("FAIL lookup_miss_content: got %h want 0", bus.lu_content_o[0]); end
  endtask

  task automatic test_arbitration();
    do_reset();
    set_lu(0, 1'b1, 16'd1, 39'h0AAA_A000);
    set_lu(1, 1'b1, 16'd2, 39'h0BBB_B000);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_port_o !== 1'b0 ||
                   bus.ptw_req_vpn_o !== 27'hAAAA || bus.ptw_req_asid_o !== 16'd1) begin
        n_err++; $display("FAIL arb_req0_hold%0d: got v=%b p=%0d vpn=%h asid=%0d want v=1 p=0 vpn=aaaa asid=1", i,
                          bus.ptw_req_valid_o, bus.ptw_req_port_o, bus.ptw_req_vpn_o, bus.ptw_req_asid_o);
      end
      if (i < 3) tick();
    end
    bus.ptw_req_ready_i = 1'b1;
    tick();
    bus.ptw_req_ready_i = 1'b0;
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b0 || walk_busy_o !== 1'b1) begin n_err++; $display("FAIL arb_wait: got v=%b busy=%b want v=0 busy=1", bus.ptw_req_valid_o, walk_busy_o); end
    fill(16'd1, 27'hAAAA, 1'b0, 1'b0, 64'h0000_0000_0AAA_A0CF);
    n_cmp++; if (walk_busy_o !== 1'b0) begin n_err++; $display("FAIL arb_idle_after_fill: got %b want 0", walk_busy_o); end
    n_cmp++; if (bus.lu_hit_o !== 2'b01) begin n_err++; $display("FAIL arb_fill_hit: got %b want 01", bus.lu_hit_o); end
    set_lu(0, 1'b1, 16'd1, 39'h0CCC_C000);
    tick();
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_port_o !== 1'b1 ||
                 bus.ptw_req_vpn_o !== 27'hBBBB || bus.ptw_req_asid_o !== 16'd2) begin
      n_err++; $display("FAIL arb_req1: got v=%b p=%0d vpn=%h asid=%0d want v=1 p=1 vpn=bbbb asid=2",
                        bus.ptw_req_valid_o, bus.ptw_req_port_o, bus.ptw_req_vpn_o, bus.ptw_req_asid_o);
    end
  endtask

  task automatic test_replacement();
    int order [7] = '{6, 4, 5, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 8; i++) fill(16'd1, 27'h100 + 27'(i), 1'b0, 1'b0, (64'(i + 1) << 10) | 64'hCF);
    for (int i = 0; i < 8; i++) begin
      set_lu(0, 1'b1, 16'd1, {12'h0, 15'h100 + 15'(i), 12'h0});
      #1;
      n_cmp++; if (bus.lu_hit_o[0] !== 1'b1) begin n_err++; $display("FAIL repl_fill_page%0d: got %b want 1", i, bus.lu_hit_o[0]); end
    end
    // This hit order leaves every tree node on the path to entry 7.
    for (int i = 0; i < 7; i++) begin
      set_lu(0, 1'b1, 16'd1, {12'h0, 15'h100 + 15'(order[i]), 12'h0});
      tick();
    end
    bus.lu_access_i = '0;
    fill(16'd1, 27'h108, 1'b0, 1'b0, 64'h0000_0000_0000_90CF);
    for (int i = 0; i < 9; i++) begin
      set_lu(0, 1'b1, 16'd1, {12'h0, 15'h100 + 15'(i), 12'h0});
      #1;
      n_cmp++; if (bus.lu_hit_o[0] !== (i != 7)) begin n_err++; $display("FAIL repl_victim_page%0d: got %b want %b", i, bus.lu_hit_o[0], (i != 7)); end
    end
    bus.lu_access_i = '0;
    fill(16'd1, 27'h100, 1'b0, 1'b0, 64'hDEAD_0000_0000_00CF);
    set_lu(0, 1'b1, 16'd1, 39'h0010_0000);
    #1;
    n_cmp++; if (bus.lu_content_o[0] !== 64'hDEAD_0000_0000_00CF) begin n_err++; $display("FAIL repl_refill_content: got %h want dead0000000000cf", bus.lu_content_o[0]); end
    for (int i = 1; i < 9; i++) begin
      if (i == 7) continue;
      set_lu(0, 1'b1, 16'd1, {12'h0, 15'h100 + 15'(i), 12'h0});
      #1;
      n_cmp++; if (bus.lu_hit_o[0] !== 1'b1) begin n_err++; $display("FAIL repl_refill_keep%0d: got %b want 1", i, bus.lu_hit_o[0]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill(16'd3, 27'h40000, 1'b0, 1'b1, 64'h0000_0000_4000_00EF);
    fill(16'd3, 27'h80A00, 1'b1, 1'b0, 64'h0000_0000_80A0_00CF);
    set_lu(0, 1'b1, 16'd3, 39'h0_5234_5678);
    set_lu(1, 1'b1, 16'd3, 39'h0_80A1_ABCD);
    #1;
    n_cmp++; if (bus.lu_hit_o !== 2'b11) begin n_err++; $display("FAIL flush_pre_hit: got %b want 11", bus.lu_hit_o); end
    n_cmp++; if ({bus.lu_is_1G_o[0], bus.lu_is_2M_o[0], bus.lu_is_1G_o[1], bus.lu_is_2M_o[1]} !== 4'b1001) begin
      n_err++; $display("FAIL flush_sizes: got %b want 1001", {bus.lu_is_1G_o[0], bus.lu_is_2M_o[0], bus.lu_is_1G_o[1], bus.lu_is_2M_o[1]});
    end
    set_lu(0, 1'b1, 16'd7, 39'h0_5234_5678);
    #1;
    n_cmp++; if (bus.lu_hit_o[0] !== 1'b1) begin n_err++; $display("FAIL flush_global_hit: got %b want 1", bus.lu_hit_o[0]); end
    flush_i = 1'b1; asid_fl = 16'd3; vaddr_fl = '0;
    tick();
    flush_i = 1'b0;
    n_cmp++; if (bus.lu_hit_o !== 2'b01) begin n_err++; $display("FAIL flush_asid: got %b want 01", bus.lu_hit_o); end
    flush_i = 1'b1; asid_fl = 16'd0; vaddr_fl = 39'h0_7FFF_F000;
    tick();
    flush_i = 1'b0;
    n_cmp++; if (bus.lu_hit_o[0] !== 1'b0) begin n_err++; $display("FAIL flush_vaddr_1G: got %b want 0", bus.lu_hit_o[0]); end
  endtask

  task automatic test_flush_drop();
    do_reset();
    set_lu(0, 1'b1, 16'd4, 39'h0DDD_D000);
    tick();
    flush_i = 1'b1;
    #1;
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b1) begin n_err++; $display("FAIL drop_valid_during_flush: got %b want 1", bus.ptw_req_valid_o); end
    tick();
    flush_i = 1'b0;
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b1) begin n_err++; $display("FAIL drop_valid_after_flush: got %b want 1", bus.ptw_req_valid_o); end
    bus.ptw_req_ready_i = 1'b1;
    tick();
    bus.ptw_req_ready_i = 1'b0;
    fill(16'd4, 27'hDDDD, 1'b0, 1'b0, 64'h0000_0000_0DDD_D0CF);
    n_cmp++; if (walk_busy_o !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b want 0", walk_busy_o); end
    n_cmp++; if (bus.lu_hit_o[0] !== 1'b0) begin n_err++; $display("FAIL drop_discarded: got %b want 0", bus.lu_hit_o[0]); end
    tick();
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_port_o !== 1'b0 || bus.ptw_req_vpn_o !== 27'hDDDD) begin
      n_err++; $display("FAIL drop_rerequest: got v=%b p=%0d vpn=%h want v=1 p=0 vpn=dddd", bus.ptw_req_valid_o, bus.ptw_req_port_o, bus.ptw_req_vpn_o);
    end
  endtask

  task automatic test_error_reset();
    do_reset();
    fill(16'd9, 27'h777, 1'b0, 1'b0, 64'h0000_0000_0077_70CF);
    set_lu(1, 1'b1, 16'd9, 39'h0077_7000);
    set_lu(0, 1'b1, 16'd4, 39'h0EEE_E000);
    tick();
    bus.ptw_req_ready_i = 1'b1;
    tick();
    bus.ptw_req_ready_i = 1'b0;
    n_cmp++; if (walk_busy_o !== 1'b1 || bus.ptw_req_valid_o !== 1'b0) begin n_err++; $display("FAIL err_in_wait: got busy=%b v=%b want busy=1 v=0", walk_busy_o, bus.ptw_req_valid_o); end
    bus.ptw_error_i = 1'b1;
    tick();
    bus.ptw_error_i = 1'b0;
    n_cmp++; if (walk_busy_o !== 1'b0) begin n_err++; $display("FAIL err_idle: got %b want 0", walk_busy_o); end
    n_cmp++; if (bus.lu_hit_o !== 2'b10) begin n_err++; $display("FAIL err_no_write: got %b want 10", bus.lu_hit_o); end
    tick();
    bus.ptw_req_ready_i = 1'b1;
    tick();
    bus.ptw_req_ready_i = 1'b0;
    n_cmp++; if (walk_busy_o !== 1'b1) begin n_err++; $display("FAIL err_wait_again: got %b want 1", walk_busy_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus.ptw_req_valid_o !== 1'b0 || walk_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_in_wait: got v=%b busy=%b want 0 0", bus.ptw_req_valid_o, walk_busy_o); end
    n_cmp++; if (bus.lu_hit_o !== 2'b00) begin n_err++; $display("FAIL rst_lookup_miss: got %b want 00", bus.lu_hit_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_arbitration();
    test_replacement();
    test_flush();
    test_flush_drop();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tlb_mp.md
Name: tlb_mp

Overview:
Multi-port, fully associative Sv39 TLB. It serves NUM_PORTS independent lookup ports, for example fetch and load/store sharing one TLB. Misses are arbitrated round-robin into a single outstanding page-table-walk request with a valid/ready handshake. It keeps SFENCE.VMA flush semantics and tree-PLRU replacement, and adds invalid-first allocation, duplicate-fill suppression and flush-safe discarding of in-flight walks. It sits between the per-port MMU front ends and the PTW.

Parameters:
TLB_ENTRIES, 8, entry count; power of 2, at least 2.
NUM_PORTS, 2, lookup ports; at least 1.
ASID_WIDTH, 16, ASID tag width; at least 1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  SFENCE.VMA strobe
asid_to_be_flushed_i  in  ASID_WIDTH  SFENCE rs2
vaddr_to_be_flushed_i  in  riscv::VLEN  SFENCE rs1
update_i  in  tlb_update_t  fill from PTW (valid, is_2M, is_1G, vpn[26:0], asid, content)
ptw_error_i  in  1  walk ended with fault; no fill follows
lu_access_i  in  [NUM_PORTS]  lookup valid per port
lu_asid_i  in  [NUM_PORTS][ASID_WIDTH]  lookup ASID
lu_vaddr_i  in  [NUM_PORTS][riscv::VLEN]  lookup vaddr
lu_hit_o  out  [NUM_PORTS]  hit
lu_content_o  out  [NUM_PORTS] riscv::pte_t  hit PTE
lu_is_2M_o / lu_is_1G_o  out  [NUM_PORTS]  hit page size
ptw_req_valid_o  out  1  walk request valid
ptw_req_ready_i  in  1  PTW accepts request
ptw_req_port_o  out  $clog2(NUM_PORTS) (min 1)  requesting port
ptw_req_vpn_o  out  27  request VPN
ptw_req_asid_o  out  ASID_WIDTH  request ASID
walk_busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all entries invalid, content 0, PLRU tree 0, round-robin pointer 0, FSM IDLE, drop flag 0. ptw_req_valid_o=0, walk_busy_o=0, request fields 0.
- Lookup is combinational with zero latency, per port. An entry matches when all hold: valid; ASID equal or PTE.g=1; vpn2 equal. Then one of: is_1G; or vpn1 equal and (is_2M or vpn0 equal). On a miss, all outputs are 0. More than one matching entry is illegal (assertion).
- PLRU: for each port p with access and hit, the path to the hit entry is set, applied in order p=0..NUM_PORTS-1. Where paths share nodes, the higher port wins.
- Victim: the lowest-index invalid entry if any; otherwise the PLRU-decoded entry.
- Fill: on update_i.valid, if a valid entry has equal asid, vpn and page size, it is overwritten. Otherwise the victim is written. The written entry becomes valid and the PLRU is not touched. A fill is accepted in any FSM state unless it is dropped (see below).
- Flush (flush_i=1), with a the flush ASID, v the flush vaddr, and "page match" meaning a 4K/2M/1G-aware VPN compare:
  - a=0 and v=0: invalidate all entries.
  - a=0 and v≠0: invalidate page-matching entries.
  - a≠0 and v≠0: invalidate non-global entries that page-match with ASID equal.
  - a≠0 and v=0: invalidate non-global entries with ASID equal.
  - Flush beats a same-cycle fill; the fill is discarded.
- Miss FSM:
  - IDLE: if any port has access and no hit, grant the first missing port at or after rr_ptr (wrapping). Latch port, vpn=vaddr[38:12] and ASID. Set rr_ptr=granted+1 mod NUM_PORTS. Go to REQ. No grant in a cycle with flush_i=1.
  - REQ: ptw_req_valid_o=1 with fields stable until ptw_req_ready_i; then go to WAIT. valid never drops while in REQ, even on flush.
  - WAIT: update_i.valid or ptw_error_i returns to IDLE.
- Drop flag: set by flush_i in REQ or WAIT; cleared on return to IDLE. A WAIT-state fill with the drop flag set, or with a same-cycle flush, is not written.
- A miss in REQ/WAIT is not latched. The port must keep lu_access_i asserted and it re-arbitrates after IDLE.

Test Plan:
1. Fill asid=5, vpn=0x12345, 4K, g=0, then lookup asid=5 at vaddr 0x12345_678 -> hit, content matches, same cycle. Lookup with asid=6 -> miss.
2. Ports 0 and 1 miss together with rr_ptr=0 -> port 0 granted. Request held with ptw_req_ready_i=0 for 3 cycles, fields unchanged. After the fill for port 0, port 1 is granted next.
3. Fill 8 distinct 4K pages -> entries 0..7 in order. Hit entries 0..6 -> ninth fill replaces entry 7. Refill an existing vpn/asid -> same index overwritten, no new entry used.
4. Global 1G page plus non-global 2M page, both asid=3. Flush a=3, v=0 -> only the 2M entry invalidated. Flush a=0, v inside the 1G page -> 1G entry invalidated.
5. Miss in REQ, flush_i pulsed, ready=1, then fill -> fill discarded, FSM back in IDLE, port misses again and re-requests.
6. ptw_error_i in WAIT -> IDLE, no entry written. Reset asserted in WAIT -> ptw_req_valid_o=0 and all lookups miss immediately.
